// File: rtl/econ_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : econ_seq_pkg
// Purpose  : Shared types, widths and round-robin grant helper for the
//            econV0 frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package econ_seq_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int IN_W    = 864;
    localparam int OUT_W   = 54;
    localparam int MAX_REQ = 8;

    // First valid requester at or after ptr, wrapping modulo nreq.
    function automatic logic [2:0] rr_grant(
        input logic [MAX_REQ-1:0] vld,
        input logic [2:0]         ptr,
        input int                 nreq
    );
        logic [2:0] g;
        logic       found;
        int         idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % nreq;
            if (!found && (k < nreq) && vld[idx[2:0]]) begin
                g     = idx[2:0];
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/econ_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : econ_tag_fifo
// Purpose  : Synchronous FIFO of requester tags, one entry per frame in
//            flight at the core.
// Revision : 1.0 - initial release
// ============================================================================
module econ_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/econ_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : econ_frame_sequencer
// Purpose  : Round-robin sharing of one econV0 core among NREQ frame sources
//            with tagged in-order responses and a stall watchdog.
//            Optional perf counters: define ECON_SEQ_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module econ_frame_sequencer #(
    parameter int  NREQ         = 4,
    parameter int  IN_W         = econ_seq_pkg::IN_W,
    parameter int  OUT_W        = econ_seq_pkg::OUT_W,
    parameter int  MAX_INFLIGHT = 4,
    parameter int  TIMEOUT      = 1024,
    localparam int ID_W         = $clog2(NREQ),
    localparam int CNT_W        = $clog2(MAX_INFLIGHT) + 1,
    localparam int WD_W         = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ*IN_W-1:0] req_dat,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    output logic [IN_W-1:0]      core_in_dat,
    output logic                 core_in_vld,
    input  logic                 core_in_rdy,
    input  logic [OUT_W-1:0]     core_out_dat,
    input  logic                 core_out_vld,
    output logic                 core_out_rdy,
    output logic [OUT_W-1:0]     rsp_dat,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic [CNT_W-1:0]     inflight,
    output logic                 timeout_err
`ifdef ECON_SEQ_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_returned
`endif
);

    import econ_seq_pkg::*;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_grant;
    logic [ID_W-1:0]       w_grant;
    logic [IN_W-1:0]       r_core_in_dat;
    logic [MAX_REQ-1:0]    w_vld_pad;
    logic                  w_any;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [WD_W-1:0]       r_wd_cnt;
    logic [WD_W-1:0]       w_wd_nxt;
    logic                  r_timeout_err;

    always_comb begin
        w_vld_pad             = '0;
        w_vld_pad[NREQ-1:0]   = req_vld;
    end

    assign w_grant = ID_W'(rr_grant(w_vld_pad, 3'(r_rr_ptr), NREQ));
    assign w_any   = |req_vld;

    always_comb begin
        w_state_nxt = r_state;
        req_rdy     = '0;
        w_push      = 1'b0;
        core_in_vld = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any && !w_fifo_full) begin
                    req_rdy[w_grant] = 1'b1;
                    w_push           = 1'b1;
                    w_state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                core_in_vld = 1'b1;
                if (core_in_rdy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_grant       <= '0;
            r_core_in_dat <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_core_in_dat <= req_dat[w_grant*IN_W +: IN_W];
                r_grant       <= w_grant;
            end
            // Pointer only advances once the core has actually taken the frame.
            if (r_state == ISSUE && core_in_rdy) begin
                r_rr_ptr <= (r_grant == ID_W'(NREQ - 1)) ? '0 : r_grant + 1'b1;
            end
        end
    end

    assign core_in_dat = r_core_in_dat;

    econ_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .W     (ID_W)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_grant),
        .dout  (rsp_id),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (inflight)
    );

    // An empty tag FIFO blocks stray core results from reaching the consumer.
    assign rsp_dat      = core_out_dat;
    assign rsp_vld      = core_out_vld && !w_fifo_empty;
    assign core_out_rdy = rsp_rdy && !w_fifo_empty;
    assign w_pop        = core_out_vld && core_out_rdy;

    always_comb begin
        if (w_pop || inflight == '0) begin
            w_wd_nxt = '0;
        end else if (r_wd_cnt != WD_W'(TIMEOUT)) begin
            w_wd_nxt = r_wd_cnt + 1'b1;
        end else begin
            w_wd_nxt = r_wd_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wd_cnt <= w_wd_nxt;
            if (w_wd_nxt == WD_W'(TIMEOUT)) r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;

`ifdef ECON_SEQ_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_returned;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_issued   <= '0;
            r_perf_returned <= '0;
        end else begin
            if (core_in_vld && core_in_rdy) r_perf_issued <= r_perf_issued + 32'd1;
            if (w_pop)                      r_perf_returned <= r_perf_returned + 32'd1;
        end
    end

    assign perf_issued   = r_perf_issued;
    assign perf_returned = r_perf_returned;
`endif

endmodule
`default_nettype wire

// File: tb/tb_econ_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_econ_frame_sequencer
// Purpose  : Self-checking bench for econ_frame_sequencer with a queue-based
//            reference model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_econ_frame_sequencer;

    localparam int NREQ    = 4;
    localparam int IN_W    = 864;
    localparam int OUT_W   = 54;
    localparam int MAXI    = 4;
    localparam int TIMEOUT = 1024;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ*IN_W-1:0] req_dat;
    logic [NREQ-1:0]      req_vld;
    logic [NREQ-1:0]      req_rdy;
    logic [IN_W-1:0]      core_in_dat;
    logic                 core_in_vld;
    logic                 core_in_rdy;
    logic [OUT_W-1:0]     core_out_dat;
    logic                 core_out_vld;
    logic                 core_out_rdy;
    logic [OUT_W-1:0]     rsp_dat;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_vld;
    logic                 rsp_rdy;
    logic [CNT_W-1:0]     inflight;
    logic                 timeout_err;

    econ_frame_sequencer #(
        .NREQ         (NREQ),
        .IN_W         (IN_W),
        .OUT_W        (OUT_W),
        .MAX_INFLIGHT (MAXI),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_dat      (req_dat),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .core_in_dat  (core_in_dat),
        .core_in_vld  (core_in_vld),
        .core_in_rdy  (core_in_rdy),
        .core_out_dat (core_out_dat),
        .core_out_vld (core_out_vld),
        .core_out_rdy (core_out_rdy),
        .rsp_dat      (rsp_dat),
        .rsp_id       (rsp_id),
        .rsp_vld      (rsp_vld),
        .rsp_rdy      (rsp_rdy),
        .inflight     (inflight),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] mkframe(input int n);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(n);
        return {27{w}};
    endfunction

    // ---------------- reference model ----------------
    bit              m_valid = 0;
    bit              m_busy  = 0;
    bit              m_err   = 0;
    logic [IN_W-1:0] m_frame;
    int              m_id  = 0;
    int              m_ptr = 0;
    int              m_wd  = 0;
    int              m_tags[$];

    function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_valid = 1;
            m_busy  = 0;
            m_err   = 0;
            m_ptr   = 0;
            m_wd    = 0;
            m_tags.delete();
        end else if (m_valid) begin
            int g;
            bit pop;
            bit push;
            g    = model_grant(req_vld, m_ptr);
            pop  = core_out_vld && rsp_rdy && (m_tags.size() > 0);
            push = !m_busy && (g >= 0) && (m_tags.size() < MAXI);
            if (pop || m_tags.size() == 0) m_wd = 0;
            else if (m_wd < TIMEOUT)       m_wd++;
            if (m_wd == TIMEOUT) m_err = 1;
            if (pop) void'(m_tags.pop_front());
            if (m_busy) begin
                if (core_in_rdy) begin
                    m_busy = 0;
                    m_ptr  = (m_id + 1) % NREQ;
                end
            end else if (push) begin
                m_busy  = 1;
                m_id    = g;
                m_frame = req_dat[g*IN_W +: IN_W];
                m_tags.push_back(g);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            int              g;
            logic [NREQ-1:0] er;
            bit              hv;
            g  = model_grant(req_vld, m_ptr);
            er = '0;
            if (!m_busy && g >= 0 && m_tags.size() < MAXI) er[g] = 1'b1;
            hv = (m_tags.size() > 0);
            check("model req_rdy", IN_W'(req_rdy), IN_W'(er));
            check("model core_in_vld", IN_W'(core_in_vld), IN_W'(m_busy));
            if (m_busy) check("model core_in_dat", core_in_dat, m_frame);
            check("model inflight", IN_W'(inflight), IN_W'(m_tags.size()));
            check("model rsp_vld", IN_W'(rsp_vld), IN_W'(core_out_vld && hv));
            check("model core_out_rdy", IN_W'(core_out_rdy), IN_W'(rsp_rdy && hv));
            if (core_out_vld && hv) begin
                check("model rsp_id", IN_W'(rsp_id), IN_W'(m_tags[0]));
                check("model rsp_dat", IN_W'(rsp_dat), IN_W'(core_out_dat));
            end
            check("model timeout_err", IN_W'(timeout_err), IN_W'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        req_vld      = '0;
        core_in_rdy  = 1'b0;
        core_out_vld = 1'b0;
        rsp_rdy      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int grants[$];
    int ids[$];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    logic [IN_W-1:0]  f_single;
    logic [OUT_W-1:0] r_single;

    initial begin
        req_vld      = '0;
        req_dat      = '0;
        core_in_rdy  = 1'b0;
        core_out_vld = 1'b0;
        core_out_dat = '0;
        rsp_rdy      = 1'b1;
        for (int i = 0; i < NREQ; i++) req_dat[i*IN_W +: IN_W] = mkframe(i);

        do_reset();
        @(negedge clk);
        check("reset core_in_dat", core_in_dat, '0);
        check("reset core_in_vld", IN_W'(core_in_vld), '0);
        check("reset inflight", IN_W'(inflight), '0);
        check("reset timeout_err", IN_W'(timeout_err), '0);
        tick();

        // single frame from requester 2
        f_single = mkframe(100);
        r_single = 54'h1A_BCDE_F012_345;
        req_dat[2*IN_W +: IN_W] = f_single;
        req_vld = 4'b0100;
        @(negedge clk);
        check("single req_rdy", IN_W'(req_rdy), IN_W'(4'b0100));
        tick();
        req_vld = '0;
        @(negedge clk);
        check("single core_in_vld", IN_W'(core_in_vld), IN_W'(1));
        check("single core_in_dat", core_in_dat, f_single);
        tick();
        core_in_rdy = 1'b1;
        @(negedge clk);
        check("single held vld", IN_W'(core_in_vld), IN_W'(1));
        tick();
        core_in_rdy  = 1'b0;
        core_out_vld = 1'b1;
        core_out_dat = r_single;
        @(negedge clk);
        check("single rsp_vld", IN_W'(rsp_vld), IN_W'(1));
        check("single rsp_id", IN_W'(rsp_id), IN_W'(2));
        check("single rsp_dat", IN_W'(rsp_dat), IN_W'(r_single));
        tick();
        core_out_vld = 1'b0;
        @(negedge clk);
        check("single inflight", IN_W'(inflight), '0);
        tick();

        // contention: all requesters valid, core always ready, results immediate
        do_reset();
        for (int i = 0; i < NREQ; i++) req_dat[i*IN_W +: IN_W] = mkframe(10 + i);
        req_vld      = 4'b1111;
        core_in_rdy  = 1'b1;
        core_out_vld = 1'b1;
        for (int c = 0; c < 12; c++) begin
            core_out_dat = 54'(1000 + c);
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) if (req_rdy[i]) grants.push_back(i);
            if (rsp_vld) ids.push_back(int'(rsp_id));
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("contention grant%0d", k),
                  IN_W'(grants.size() > k ? grants[k] : -1), IN_W'(exp_seq[k]));
            check($sformatf("contention rsp_id%0d", k),
                  IN_W'(ids.size() > k ? ids[k] : -1), IN_W'(exp_seq[k]));
        end
        req_vld = '0;
        repeat (4) tick();
        core_out_vld = 1'b0;

        // backpressure: core results withheld until the FIFO fills
        do_reset();
        req_vld     = 4'b1111;
        core_in_rdy = 1'b1;
        begin
            int c;
            c = 0;
            while (inflight != CNT_W'(MAXI) && c < 30) begin
                tick();
                c++;
            end
        end
        check("bp inflight reached", IN_W'(inflight), IN_W'(MAXI));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp req_rdy blocked", IN_W'(req_rdy), '0);
            check("bp inflight full", IN_W'(inflight), IN_W'(4));
            tick();
        end
        core_out_vld = 1'b1;
        core_out_dat = 54'h55;
        @(negedge clk);
        check("bp head id", IN_W'(rsp_id), IN_W'(0));
        tick();
        core_out_vld = 1'b0;
        @(negedge clk);
        check("bp req_rdy reenabled", IN_W'(req_rdy), IN_W'(4'b0001));
        check("bp inflight after pop", IN_W'(inflight), IN_W'(3));
        tick();

        // simultaneous push and pop at inflight 2
        do_reset();
        req_vld     = 4'b1111;
        core_in_rdy = 1'b1;
        repeat (4) tick();
        core_out_vld = 1'b1;
        core_out_dat = 54'h77;
        @(negedge clk);
        check("simul inflight before", IN_W'(inflight), IN_W'(2));
        check("simul req_rdy", IN_W'(req_rdy), IN_W'(4'b0100));
        check("simul head0", IN_W'(rsp_id), IN_W'(0));
        tick();
        req_vld = '0;
        @(negedge clk);
        check("simul inflight after", IN_W'(inflight), IN_W'(2));
        check("simul head1", IN_W'(rsp_id), IN_W'(1));
        tick();
        @(negedge clk);
        check("simul head2", IN_W'(rsp_id), IN_W'(2));
        tick();
        core_out_vld = 1'b0;
        @(negedge clk);
        check("simul drained", IN_W'(inflight), '0);
        tick();

        // watchdog: one frame outstanding with no result
        do_reset();
        req_vld     = 4'b0001;
        core_in_rdy = 1'b1;
        tick();
        req_vld = '0;
        tick();
        repeat (TIMEOUT - 2) tick();
        @(negedge clk);
        check("wd not yet", IN_W'(timeout_err), '0);
        tick();
        @(negedge clk);
        check("wd fired", IN_W'(timeout_err), IN_W'(1));
        tick();
        core_out_vld = 1'b1;
        core_out_dat = 54'h99;
        @(negedge clk);
        check("wd late rsp_vld", IN_W'(rsp_vld), IN_W'(1));
        tick();
        core_out_vld = 1'b0;
        @(negedge clk);
        check("wd sticky", IN_W'(timeout_err), IN_W'(1));
        check("wd inflight", IN_W'(inflight), '0);
        tick();

        // reset while a frame is being issued
        do_reset();
        req_vld     = 4'b0010;
        core_in_rdy = 1'b1;
        tick();
        req_vld = '0;
        tick();
        req_vld     = 4'b0100;
        core_in_rdy = 1'b0;
        tick();
        req_vld = '0;
        @(negedge clk);
        check("rst mid issue vld", IN_W'(core_in_vld), IN_W'(1));
        tick();
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        core_out_vld = 1'b1;
        req_vld      = 4'b1111;
        @(negedge clk);
        check("rst core_in_vld cleared", IN_W'(core_in_vld), '0);
        check("rst inflight cleared", IN_W'(inflight), '0);
        check("rst stray core_out_rdy", IN_W'(core_out_rdy), '0);
        check("rst stray rsp_vld", IN_W'(rsp_vld), '0);
        check("rst rr_ptr zero", IN_W'(req_rdy), IN_W'(4'b0001));
        tick();
        core_out_vld = 1'b0;
        req_vld      = '0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
